// File: rtl/gpu_pkg.sv
// Shared types and width defaults for the data-memory controller and its
// per-channel FSMs.
package gpu_pkg;

    localparam int DEFAULT_ADDR_BITS = 8;
    localparam int DEFAULT_DATA_BITS = 8;

    typedef enum logic [2:0] {
        CH_IDLE           = 3'd0,
        CH_READ_WAITING   = 3'd1,
        CH_WRITE_WAITING  = 3'd2,
        CH_READ_RELAYING  = 3'd3,
        CH_WRITE_RELAYING = 3'd4
    } ch_state_e;

    // Index width that stays legal (>= 1 bit) for a single consumer.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_channel_fsm.sv
// One external memory channel: takes a grant from the top-level arbiter,
// issues a single memory request and relays the response back to its owner.
module mem_channel_fsm
    import gpu_pkg::*;
#(
    parameter int ADDR_BITS     = DEFAULT_ADDR_BITS,
    parameter int DATA_BITS     = DEFAULT_DATA_BITS,
    parameter int NUM_CONSUMERS = 4,
    parameter int IDX_BITS      = idx_bits(NUM_CONSUMERS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     grant_valid,
    input  logic                     grant_read,
    input  logic [IDX_BITS-1:0]      grant_idx,
    input  logic [ADDR_BITS-1:0]     grant_addr,
    input  logic [DATA_BITS-1:0]     grant_data,
    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
    input  logic                     mem_read_ready,
    input  logic [DATA_BITS-1:0]     mem_read_data,
    input  logic                     mem_write_ready,
    output logic                     idle,
    output logic                     release_claim,
    output logic [IDX_BITS-1:0]      owner,
    output logic                     read_ready,
    output logic                     write_ready,
    output logic [DATA_BITS-1:0]     read_data,
    output logic                     mem_read_valid,
    output logic [ADDR_BITS-1:0]     mem_read_address,
    output logic                     mem_write_valid,
    output logic [ADDR_BITS-1:0]     mem_write_address,
    output logic [DATA_BITS-1:0]     mem_write_data
);

    ch_state_e             state_q, state_d;
    logic [IDX_BITS-1:0]   owner_q, owner_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [DATA_BITS-1:0]  wdata_q, wdata_d;
    logic [DATA_BITS-1:0]  rdata_q, rdata_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  wr_valid_q, wr_valid_d;
    logic                  rd_ready_q, rd_ready_d;
    logic                  wr_ready_q, wr_ready_d;

    always_comb begin
        // NOTE: every _d starts as its _q so no branch leaves a value unassigned (no latch).
        state_d       = state_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        rd_valid_d    = rd_valid_q;
        wr_valid_d    = wr_valid_q;
        rd_ready_d    = rd_ready_q;
        wr_ready_d    = wr_ready_q;
        release_claim = 1'b0;
        case (state_q)
            CH_IDLE: begin
                if (grant_valid) begin
                    owner_d = grant_idx;
                    addr_d  = grant_addr;
                    wdata_d = grant_data;
                    if (grant_read) begin
                        rd_valid_d = 1'b1;
                        state_d    = CH_READ_WAITING;
                    end else begin
                        wr_valid_d = 1'b1;
                        state_d    = CH_WRITE_WAITING;
                    end
                end
            end
            CH_READ_WAITING: begin
                if (mem_read_ready) begin
                    rd_valid_d = 1'b0;
                    rd_ready_d = 1'b1;
                    rdata_d    = mem_read_data;
                    state_d    = CH_READ_RELAYING;
                end
            end
            CH_WRITE_WAITING: begin
                if (mem_write_ready) begin
                    wr_valid_d = 1'b0;
                    wr_ready_d = 1'b1;
                    state_d    = CH_WRITE_RELAYING;
                end
            end
            // Response is held until the owner withdraws its request.
            CH_READ_RELAYING: begin
                if (!consumer_read_valid[owner_q]) begin
                    rd_ready_d    = 1'b0;
                    release_claim = 1'b1;
                    state_d       = CH_IDLE;
                end
            end
            CH_WRITE_RELAYING: begin
                if (!consumer_write_valid[owner_q]) begin
                    wr_ready_d    = 1'b0;
                    release_claim = 1'b1;
                    state_d       = CH_IDLE;
                end
            end
            default: state_d = CH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= CH_IDLE;
            owner_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
            rd_ready_q <= 1'b0;
            wr_ready_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            wr_valid_q <= wr_valid_d;
            rd_ready_q <= rd_ready_d;
            wr_ready_q <= wr_ready_d;
        end
    end

    assign idle              = (state_q == CH_IDLE);
    assign owner             = owner_q;
    assign read_ready        = rd_ready_q;
    assign write_ready       = wr_ready_q;
    assign read_data         = rdata_q;
    assign mem_read_valid    = rd_valid_q;
    assign mem_write_valid   = wr_valid_q;
    assign mem_read_address  = rd_valid_q ? addr_q : '0;
    assign mem_write_address = wr_valid_q ? addr_q : '0;
    assign mem_write_data    = wr_valid_q ? wdata_q : '0;

endmodule

// File: rtl/data_mem_controller.sv
// Arbitrates per-thread data-memory request ports onto a set of external
// memory channels with round-robin selection and a shared claim mask.
module data_mem_controller
    import gpu_pkg::*;
#(
    parameter int ADDR_BITS     = DEFAULT_ADDR_BITS,
    parameter int DATA_BITS     = DEFAULT_DATA_BITS,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
    output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
);

    localparam int IDX_BITS = idx_bits(NUM_CONSUMERS);

    logic [NUM_CONSUMERS-1:0]                claim_q, claim_d, taken, released;
    logic [NUM_CONSUMERS-1:0]                req_read, req_write, req_any, wr_ready_all;
    logic [NUM_CHANNELS-1:0][IDX_BITS-1:0]   rr_q, rr_d, grant_idx, ch_owner;
    logic [NUM_CHANNELS-1:0]                 grant_valid, grant_read;
    logic [NUM_CHANNELS-1:0]                 ch_idle, ch_release, ch_read_ready, ch_write_ready;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  ch_read_data, ch_mem_write_data;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  ch_mem_write_address;
    logic [NUM_CHANNELS-1:0]                 ch_mem_write_valid;
    logic [IDX_BITS-1:0]                     cand;

    assign req_read  = consumer_read_valid;
    assign req_write = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;
    assign req_any   = req_read | req_write;

    // Channels are visited in index order so a lower channel's pick is already
    // marked taken when a higher channel scans.
    always_comb begin
        taken       = claim_q;
        grant_valid = '0;
        grant_read  = '0;
        grant_idx   = rr_q;
        cand        = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            for (int k = 1; k <= NUM_CONSUMERS; k++) begin
                cand = IDX_BITS'((int'(rr_q[c]) + k) % NUM_CONSUMERS);
                if (ch_idle[c] && !grant_valid[c] && req_any[cand] && !taken[cand]) begin
                    grant_valid[c] = 1'b1;
                    grant_idx[c]   = cand;
                    grant_read[c]  = req_read[cand];
                    taken[cand]    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        released             = '0;
        wr_ready_all         = '0;
        consumer_read_ready  = '0;
        consumer_read_data   = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (ch_release[c])     released[ch_owner[c]] = 1'b1;
            if (ch_write_ready[c]) wr_ready_all[ch_owner[c]] = 1'b1;
            if (ch_read_ready[c]) begin
                consumer_read_ready[ch_owner[c]] = 1'b1;
                consumer_read_data[ch_owner[c]]  = ch_read_data[c];
            end
        end
    end

    always_comb begin
        claim_d = taken & ~released;
        rr_d    = rr_q;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (grant_valid[c]) rr_d[c] = grant_idx[c];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            claim_q <= '0;
            rr_q    <= '0;
        end else begin
            claim_q <= claim_d;
            rr_q    <= rr_d;
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [ADDR_BITS-1:0] grant_addr;
        assign grant_addr = grant_read[c] ? consumer_read_address[grant_idx[c]]
                                          : consumer_write_address[grant_idx[c]];

        mem_channel_fsm #(
            .ADDR_BITS     (ADDR_BITS),
            .DATA_BITS     (DATA_BITS),
            .NUM_CONSUMERS (NUM_CONSUMERS),
            .IDX_BITS      (IDX_BITS)
        ) u_fsm (
            .clk                  (clk),
            .reset                (reset),
            .grant_valid          (grant_valid[c]),
            .grant_read           (grant_read[c]),
            .grant_idx            (grant_idx[c]),
            .grant_addr           (grant_addr),
            .grant_data           (consumer_write_data[grant_idx[c]]),
            .consumer_read_valid  (consumer_read_valid),
            .consumer_write_valid (req_write),
            .mem_read_ready       (mem_read_ready[c]),
            .mem_read_data        (mem_read_data[c]),
            .mem_write_ready      (mem_write_ready[c]),
            .idle                 (ch_idle[c]),
            .release_claim        (ch_release[c]),
            .owner                (ch_owner[c]),
            .read_ready           (ch_read_ready[c]),
            .write_ready          (ch_write_ready[c]),
            .read_data            (ch_read_data[c]),
            .mem_read_valid       (mem_read_valid[c]),
            .mem_read_address     (mem_read_address[c]),
            .mem_write_valid      (ch_mem_write_valid[c]),
            .mem_write_address    (ch_mem_write_address[c]),
            .mem_write_data       (ch_mem_write_data[c])
        );
    end

    if (WRITE_ENABLE != 0) begin : g_wr
        assign mem_write_valid      = ch_mem_write_valid;
        assign mem_write_address    = ch_mem_write_address;
        assign mem_write_data       = ch_mem_write_data;
        assign consumer_write_ready = wr_ready_all;
    end else begin : g_no_wr
        assign mem_write_valid      = '0;
        assign mem_write_address    = '0;
        assign mem_write_data       = '0;
        assign consumer_write_ready = '0;
    end

endmodule

// File: tb/tb_data_mem_controller.sv
// Scoreboard bench for data_mem_controller with two channels: directed cases
// followed by concurrent randomized traffic against a reference memory.
module tb_data_mem_controller;

    localparam int AB  = 8;
    localparam int DB  = 8;
    localparam int NC  = 4;
    localparam int NCH = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [NC-1:0]           c_rvalid, c_wvalid;
    logic [NC-1:0][AB-1:0]   c_raddr, c_waddr;
    logic [NC-1:0][DB-1:0]   c_wdata;
    logic [NC-1:0]           consumer_read_ready, consumer_write_ready;
    logic [NC-1:0][DB-1:0]   consumer_read_data;
    logic [NCH-1:0]          mem_read_valid, mem_write_valid;
    logic [NCH-1:0][AB-1:0]  mem_read_address, mem_write_address;
    logic [NCH-1:0][DB-1:0]  mem_write_data, m_rdata;
    logic [NCH-1:0]          m_rready, m_wready;

    data_mem_controller #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC),
        .NUM_CHANNELS(NCH), .WRITE_ENABLE(1)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (c_rvalid),
        .consumer_read_address  (c_raddr),
        .consumer_read_ready    (consumer_read_ready),
        .consumer_read_data     (consumer_read_data),
        .consumer_write_valid   (c_wvalid),
        .consumer_write_address (c_waddr),
        .consumer_write_data    (c_wdata),
        .consumer_write_ready   (consumer_write_ready),
        .mem_read_valid         (mem_read_valid),
        .mem_read_address       (mem_read_address),
        .mem_read_ready         (m_rready),
        .mem_read_data          (m_rdata),
        .mem_write_valid        (mem_write_valid),
        .mem_write_address      (mem_write_address),
        .mem_write_data         (mem_write_data),
        .mem_write_ready        (m_wready)
    );

    typedef struct {
        int             id;
        bit             is_read;
        logic [DB-1:0]  data;
    } exp_t;

    exp_t          sb[$];
    logic [DB-1:0] mem       [256];
    logic [DB-1:0] model_mem [256];
    logic [DB-1:0] last_exp  [NC];
    int            checks    = 0;
    int            failures  = 0;
    int            delay_max = 0;
    bit            mem_stall = 1'b0;
    int            rd_wait [NCH];
    int            wr_wait [NCH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory responder: each request completes after a random wait, one ready pulse.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_rready <= '0;
            m_wready <= '0;
            m_rdata  <= '0;
            for (int c = 0; c < NCH; c++) begin
                rd_wait[c] <= 0;
                wr_wait[c] <= 0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (m_rready[c]) m_rready[c] <= 1'b0;
                else if (mem_read_valid[c] && !mem_stall) begin
                    if (rd_wait[c] == 0) begin
                        m_rready[c] <= 1'b1;
                        m_rdata[c]  <= mem[mem_read_address[c]];
                        rd_wait[c]  <= $urandom_range(0, delay_max);
                    end else rd_wait[c] <= rd_wait[c] - 1;
                end
                if (m_wready[c]) m_wready[c] <= 1'b0;
                else if (mem_write_valid[c] && !mem_stall) begin
                    if (wr_wait[c] == 0) begin
                        m_wready[c] <= 1'b1;
                        mem[mem_write_address[c]] <= mem_write_data[c];
                        wr_wait[c]  <= $urandom_range(0, delay_max);
                    end else wr_wait[c] <= wr_wait[c] - 1;
                end
            end
        end
    end

    task automatic sb_pop(input int id, input bit is_read, input logic [DB-1:0] data);
        int hit;
        hit = -1;
        foreach (sb[i]) if (hit < 0 && sb[i].id == id) hit = i;
        if (hit < 0) begin
            check($sformatf("unexpected_resp_c%0d", id), 1, 0);
            return;
        end
        check($sformatf("resp_kind_c%0d", id), 32'(is_read), 32'(sb[hit].is_read));
        if (is_read && sb[hit].is_read) begin
            check($sformatf("read_data_c%0d", id), 32'(data), 32'(sb[hit].data));
            last_exp[id] = sb[hit].data;
        end
        sb.delete(hit);
    endtask

    // Monitor: a rising ready pops the scoreboard; a held ready must keep its data.
    logic [NC-1:0] prev_rr = '0, prev_wr = '0;
    always @(negedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (consumer_read_ready[i] && !prev_rr[i]) sb_pop(i, 1'b1, consumer_read_data[i]);
            else if (consumer_read_ready[i])
                check($sformatf("read_hold_c%0d", i), 32'(consumer_read_data[i]), 32'(last_exp[i]));
            if (consumer_write_ready[i] && !prev_wr[i]) sb_pop(i, 1'b0, '0);
        end
        prev_rr = consumer_read_ready;
        prev_wr = consumer_write_ready;
    end

    task automatic push_exp(input int id, input bit is_read, input logic [DB-1:0] data);
        exp_t e;
        e.id = id;
        e.is_read = is_read;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic wait_ready(input int id, input bit rd);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = rd ? consumer_read_ready[id] : consumer_write_ready[id];
        end
        check($sformatf("%s_ready_timeout_c%0d", rd ? "read" : "write", id), 32'(ok), 1);
    endtask

    task automatic hold_cycles(input int n);
        for (int h = 0; h < n; h++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_txn(input int id, input bit rd, input bit wr,
                          input logic [AB-1:0] ra, input logic [AB-1:0] wa,
                          input logic [DB-1:0] wd);
        if (rd) push_exp(id, 1'b1, model_mem[ra]);
        if (wr) begin
            push_exp(id, 1'b0, '0);
            model_mem[wa] = wd;
        end
        c_raddr[id]  = ra;
        c_waddr[id]  = wa;
        c_wdata[id]  = wd;
        c_rvalid[id] = rd;
        c_wvalid[id] = wr;
        if (rd) begin
            wait_ready(id, 1'b1);
            hold_cycles($urandom_range(0, 2));
            c_rvalid[id] = 1'b0;
        end
        if (wr) begin
            wait_ready(id, 1'b0);
            hold_cycles($urandom_range(0, 2));
            c_wvalid[id] = 1'b0;
        end
        hold_cycles(1);
    endtask

    // Each consumer works in its own quarter of the address space.
    task automatic run_random(input int id);
        for (int n = 0; n < 12; n++) begin
            int op;
            logic [AB-1:0] ra, wa;
            logic [DB-1:0] wd;
            op = $urandom_range(0, 2);
            ra = {2'(id), 6'($urandom)};
            wa = {2'(id), 6'($urandom)};
            wd = 8'($urandom);
            do_txn(id, op != 1, op != 0, ra, wa, wd);
            hold_cycles($urandom_range(0, 2));
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        hold_cycles(2);
        reset = 1'b1;
        hold_cycles(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        for (int i = 0; i < 256; i++) begin
            mem[i]       = 8'(i * 7 + 3);
            model_mem[i] = mem[i];
        end
        mem[8'h12] = 8'hAB; model_mem[8'h12] = 8'hAB;
        mem[8'h77] = 8'h5A; model_mem[8'h77] = 8'h5A;
        for (int i = 0; i < NC; i++) last_exp[i] = '0;
        c_rvalid = '0; c_wvalid = '0; c_raddr = '0; c_waddr = '0; c_wdata = '0;

        hold_cycles(3);
        check("rst_cons_read_ready",  32'(consumer_read_ready), 0);
        check("rst_cons_write_ready", 32'(consumer_write_ready), 0);
        check("rst_cons_read_data",   32'(consumer_read_data), 0);
        check("rst_mem_read_valid",   32'(mem_read_valid), 0);
        check("rst_mem_write_valid",  32'(mem_write_valid), 0);
        check("rst_mem_read_addr",    32'(mem_read_address), 0);
        reset = 1'b1;
        hold_cycles(1);

        // Single read, consumer 0, addr 0x12, single-cycle memory.
        push_exp(0, 1'b1, model_mem[8'h12]);
        c_raddr[0] = 8'h12;
        c_rvalid[0] = 1'b1;
        hold_cycles(1);
        check("rd1_mem_valid", 32'(mem_read_valid[0]), 1);
        check("rd1_mem_addr",  32'(mem_read_address[0]), 32'h12);
        lat = 1;
        for (int i = 0; i < 20 && !consumer_read_ready[0]; i++) begin
            hold_cycles(1);
            lat++;
        end
        check("rd1_latency", 32'(lat), 3);
        check("rd1_mem_valid_low", 32'(mem_read_valid[0]), 0);
        hold_cycles(2);
        c_rvalid[0] = 1'b0;
        hold_cycles(1);
        check("rd1_ready_drop", 32'(consumer_read_ready[0]), 0);

        // Single write, consumer 2, addr 0x05 data 0x3C.
        push_exp(2, 1'b0, '0);
        model_mem[8'h05] = 8'h3C;
        c_waddr[2] = 8'h05; c_wdata[2] = 8'h3C; c_wvalid[2] = 1'b1;
        hold_cycles(1);
        check("wr1_mem_valid", 32'(mem_write_valid[0]), 1);
        check("wr1_mem_addr",  32'(mem_write_address[0]), 32'h05);
        check("wr1_mem_data",  32'(mem_write_data[0]), 32'h3C);
        wait_ready(2, 1'b0);
        check("wr1_mem_valid_low", 32'(mem_write_valid), 0);
        c_wvalid[2] = 1'b0;
        hold_cycles(1);
        check("wr1_ready_drop", 32'(consumer_write_ready[2]), 0);

        // Read and write together: scoreboard order requires the read first.
        do_txn(1, 1'b1, 1'b1, 8'h40, 8'h41, 8'hC7);

        // Reset while a read is stalled in the waiting state.
        mem_stall = 1'b1;
        push_exp(1, 1'b1, model_mem[8'h77]);
        c_raddr[1] = 8'h77;
        c_rvalid[1] = 1'b1;
        hold_cycles(2);
        check("pre_reset_mem_valid", 32'(|mem_read_valid), 1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_mem_read_valid", 32'(mem_read_valid), 0);
        check("async_rst_mem_read_addr",  32'(mem_read_address), 0);
        check("async_rst_cons_ready",     32'(consumer_read_ready | consumer_write_ready), 0);
        hold_cycles(2);
        reset = 1'b1;
        mem_stall = 1'b0;
        for (int i = 0; i < 10 && !mem_read_valid[0]; i++) hold_cycles(1);
        check("reissue_mem_valid", 32'(mem_read_valid[0]), 1);
        check("reissue_mem_addr",  32'(mem_read_address[0]), 32'h77);
        wait_ready(1, 1'b1);
        c_rvalid[1] = 1'b0;
        hold_cycles(1);

        // Contention: consumers 0 and 3 together, both pointers at 0.
        pulse_reset();
        push_exp(0, 1'b1, model_mem[8'h30]);
        push_exp(3, 1'b1, model_mem[8'hF3]);
        c_raddr[0] = 8'h30; c_raddr[3] = 8'hF3;
        c_rvalid[0] = 1'b1; c_rvalid[3] = 1'b1;
        hold_cycles(1);
        check("cont_ch0_valid", 32'(mem_read_valid[0]), 1);
        check("cont_ch0_addr",  32'(mem_read_address[0]), 32'hF3);
        check("cont_ch1_valid", 32'(mem_read_valid[1]), 1);
        check("cont_ch1_addr",  32'(mem_read_address[1]), 32'h30);
        fork
            begin wait_ready(0, 1'b1); c_rvalid[0] = 1'b0; end
            begin wait_ready(3, 1'b1); hold_cycles(1); c_rvalid[3] = 1'b0; end
        join
        hold_cycles(1);

        // All four read at once: first picks are consumers 1 and 2.
        pulse_reset();
        for (int i = 0; i < NC; i++) begin
            c_raddr[i] = {2'(i), 6'(i + 1)};
            push_exp(i, 1'b1, model_mem[c_raddr[i]]);
        end
        c_rvalid = '1;
        hold_cycles(1);
        check("all4_ch0_addr", 32'(mem_read_address[0]), 32'h42);
        check("all4_ch1_addr", 32'(mem_read_address[1]), 32'h83);
        fork
            begin wait_ready(0, 1'b1); c_rvalid[0] = 1'b0; end
            begin wait_ready(1, 1'b1); c_rvalid[1] = 1'b0; end
            begin wait_ready(2, 1'b1); c_rvalid[2] = 1'b0; end
            begin wait_ready(3, 1'b1); c_rvalid[3] = 1'b0; end
        join
        hold_cycles(1);

        // Concurrent randomized traffic with variable memory latency.
        delay_max = 2;
        fork
            run_random(0);
            run_random(1);
            run_random(2);
            run_random(3);
        join
        hold_cycles(5);

        check("sb_empty", 32'(sb.size()), 0);
        for (int i = 0; i < 256; i++)
            check($sformatf("mem_0x%02h", i), 32'(mem[i]), 32'(model_mem[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_controller.md
Name: data_mem_controller

Overview:
Downstream consumer of each core's per-thread data-memory request ports. Arbitrates NUM_CONSUMERS valid/ready request ports (thread LSUs across all cores) onto NUM_CHANNELS external memory channels, using one FSM per channel. Each channel serves one consumer request at a time. A channel relays the read data or write acknowledgement back and holds it until the consumer drops its valid.

Parameters:
ADDR_BITS, 8, data memory address width
DATA_BITS, 8, data memory word width
NUM_CONSUMERS, 4, number of request ports (cores x threads per warp)
NUM_CHANNELS, 1, number of concurrent external memory channels
WRITE_ENABLE, 1, 0 = read-only controller; write ports tied off, write requests ignored

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request
consumer_read_address  in  ADDR_BITS x NUM_CONSUMERS  read address
consumer_read_ready  out  NUM_CONSUMERS  read data valid / ack
consumer_read_data  out  DATA_BITS x NUM_CONSUMERS  returned data
consumer_write_valid  in  NUM_CONSUMERS  per-consumer write request
consumer_write_address  in  ADDR_BITS x NUM_CONSUMERS  write address
consumer_write_data  in  DATA_BITS x NUM_CONSUMERS  write data
consumer_write_ready  out  NUM_CONSUMERS  write ack
mem_read_valid  out  NUM_CHANNELS  channel read request
mem_read_address  out  ADDR_BITS x NUM_CHANNELS  channel read address
mem_read_ready  in  NUM_CHANNELS  memory read complete
mem_read_data  in  DATA_BITS x NUM_CHANNELS  memory read data
mem_write_valid  out  NUM_CHANNELS  channel write request
mem_write_address  out  ADDR_BITS x NUM_CHANNELS  write address
mem_write_data  out  DATA_BITS x NUM_CHANNELS  write data
mem_write_ready  in  NUM_CHANNELS  memory write complete

Behaviour:
- Reset (reset=0, async): all outputs 0, all channel FSMs IDLE, claim mask 0, round-robin pointers 0. A reset mid-transaction aborts it; a consumer still asserting valid is re-served from scratch after reset.
- Per-channel states: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
- IDLE:
  - Scan consumers from (rr_ptr+1) mod NUM_CONSUMERS, wrapping. Select the first consumer with read_valid or write_valid that no channel has claimed.
  - If that consumer asserts both, read wins; its write is taken on a later grant.
  - On grant: set claim bit, rr_ptr := consumer index, latch address/data.
  - Read: mem_read_valid=1, go to READ_WAITING. Write: mem_write_valid=1, go to WRITE_WAITING.
  - Registered outputs: mem valid rises 1 cycle after consumer valid is seen.
- READ_WAITING: hold valid/address until mem_read_ready=1. Then deassert mem_read_valid, drive consumer_read_ready=1 and consumer_read_data=mem_read_data (registered), go to READ_RELAYING.
- WRITE_WAITING: same on mem_write_ready. Drive consumer_write_ready=1, go to WRITE_RELAYING.
- READ_RELAYING / WRITE_RELAYING:
  - Hold ready and data while the consumer holds valid.
  - When the consumer valid is seen low: ready := 0, clear claim bit, go to IDLE.
  - The consumer may be re-granted no earlier than the following cycle.
- Same-cycle contention: if several idle channels would select the same consumer, the lowest channel index wins. Higher channels pick the next unclaimed requester in the same cycle, or stay IDLE.
- A consumer is never served by two channels at once. A channel never holds more than one outstanding memory request.
- Memory ready asserted while the channel is not WAITING: ignored.
- Latency with single-cycle memory (valid→ready next cycle): consumer valid → consumer ready = 3 cycles.
- WRITE_ENABLE=0: mem_write_* and consumer_write_ready are constant 0.

Decomposition:
- Shared package gpu_pkg: channel state enum (3-bit), ADDR/DATA width defaults.
- Natural sub-module: mem_channel_fsm (one per channel, generate loop).
- Grant/claim arbitration stays in the top level, because cross-channel priority is combinational over all channels.

Test Plan:
- Single read, consumer 0 at addr 0x12, memory returns 0xAB one cycle after valid → consumer_read_ready[0]=1 with data 0xAB 3 cycles after request; holds until valid drops; ready low the next cycle.
- Single write, consumer 2, addr 0x05, data 0x3C → mem_write_valid with 0x05/0x3C; consumer_write_ready[2] after mem_write_ready; mem_write_valid low afterwards.
- All 4 consumers read simultaneously, 1 channel → grants in order 1,2,3,0 (rr_ptr starts 0); each receives its own data; no overlap in memory requests.
- 2 channels, consumers 0 and 3 request the same cycle → channel 0 takes consumer 1-onward scan hit (3), channel 1 takes 0; both relay independently; claim mask never has a double claim.
- Consumer asserts read and write together → read is served first; the write is served on the next grant.
- reset pulsed low during READ_WAITING → all outputs 0 immediately (async); after release, the held request is re-issued with the same address.
